// File: rtl/key_matrix_scanner.sv
// 8x8 key matrix scanner: synchronizes, debounces and reports key press/release events.
// Optional KEY_TOGGLE_PATTERN_EN builds a 64-bit press-toggled pattern register.
`timescale 1ns/1ps
module key_matrix_scanner #(
  parameter int SCAN_DIV = 16,
  parameter int DEBOUNCE = 3
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  row_n,
  input  logic [7:0]  col_n,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic [5:0]  ev_code,
  output logic        ev_press,
  output logic [63:0] pattern
);

  localparam logic [15:0] PH_LAST   = 16'(SCAN_DIV - 1);
  localparam logic [15:0] PH_SAMPLE = 16'(SCAN_DIV - 9);
  localparam logic [15:0] PH_EVAL   = 16'(SCAN_DIV - 8);
  localparam logic [2:0]  EVAL_LO   = PH_EVAL[2:0];
  localparam logic [2:0]  DB        = 3'(DEBOUNCE);

  logic [7:0]  col_s1_r, col_s2_r, sample_r;
  logic [15:0] phase_r;
  logic [2:0]  row_r;
  logic [7:0]  row_n_r;
  logic [63:0] stable_r;
  logic [2:0]  cnt_r [64];
  logic [6:0]  fifo_r [4];
  logic [1:0]  wr_ptr_r, rd_ptr_r;
  logic [2:0]  count_r;

  logic        eval_s, cur_s, differ_s, fire_s, full_s, pop_s, push_s;
  logic [2:0]  col_idx_s, cnt_inc_s;
  logic [5:0]  key_s;

  // Evaluation of the one key addressed this cycle and FIFO handshake decode
  always_comb begin
    eval_s    = (phase_r >= PH_EVAL);
    col_idx_s = phase_r[2:0] - EVAL_LO;
    key_s     = {row_r, col_idx_s};
    cur_s     = sample_r[col_idx_s];
    differ_s  = (cur_s != stable_r[key_s]);
    if (cnt_r[key_s] >= DB) begin
      cnt_inc_s = DB;   // saturate while a blocked event waits for FIFO space
    end else begin
      cnt_inc_s = cnt_r[key_s] + 3'd1;
    end
    full_s = (count_r == 3'd4);
    pop_s  = ev_valid && ev_ready;
    fire_s = eval_s && differ_s && (cnt_inc_s == DB);
    push_s = fire_s && (!full_s || pop_s);
  end

  // Two-flop column synchronizer; idle value is all released
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_s1_r <= 8'hFF;
      col_s2_r <= 8'hFF;
    end else begin
      col_s1_r <= col_n;
      col_s2_r <= col_s1_r;
    end
  end

  // Row/phase scan counters, registered row drive and column sample latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_r  <= 16'd0;
      row_r    <= 3'd0;
      row_n_r  <= 8'hFE;
      sample_r <= 8'h00;
    end else begin
      if (phase_r == PH_SAMPLE) begin
        sample_r <= ~col_s2_r;
      end
      if (phase_r == PH_LAST) begin
        phase_r <= 16'd0;
        row_r   <= row_r + 3'd1;
        row_n_r <= ~(8'd1 << (row_r + 3'd1));
      end else begin
        phase_r <= phase_r + 16'd1;
      end
    end
  end

  // Per-key debounce state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable_r <= 64'h0;
      for (int k = 0; k < 64; k++) begin
        cnt_r[k] <= 3'd0;
      end
    end else if (eval_s) begin
      if (!differ_s) begin
        cnt_r[key_s] <= 3'd0;
      end else if (push_s) begin
        stable_r[key_s] <= cur_s;
        cnt_r[key_s]    <= 3'd0;
      end else begin
        cnt_r[key_s] <= cnt_inc_s;
      end
    end
  end

  // Four-entry first-word-fall-through event FIFO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= 2'd0;
      rd_ptr_r <= 2'd0;
      count_r  <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        fifo_r[i] <= 7'd0;
      end
    end else begin
      if (push_s) begin
        fifo_r[wr_ptr_r] <= {key_s, cur_s};
        wr_ptr_r         <= wr_ptr_r + 2'd1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 2'd1;
      end
      count_r <= count_r + {2'b00, push_s} - {2'b00, pop_s};
    end
  end

  assign row_n    = row_n_r;
  assign ev_valid = (count_r != 3'd0);
  assign ev_code  = fifo_r[rd_ptr_r][6:1];
  assign ev_press = fifo_r[rd_ptr_r][0];

`ifdef KEY_TOGGLE_PATTERN_EN
  logic [63:0] pattern_r;

  // Each accepted press flips its pattern bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pattern_r <= 64'h0;
    end else if (push_s && cur_s) begin
      pattern_r <= pattern_r ^ (64'd1 << key_s);
    end
  end

  assign pattern = pattern_r;
`else
  assign pattern = 64'h0;
`endif

endmodule
